// File: rtl/layer_sequencer.sv
// Run controller: steps NUM_STAGES chained stages through enable/STOP, muxes the active stage
// onto the shared pixel memory and latches the final class index. Optional watchdog: WATCHDOG_EN.
module layer_sequencer #(
    parameter int NUM_STAGES       = 4,
    parameter int SIZE_address_pix = 13,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    output logic [NUM_STAGES-1:0]                  stage_en,
    input  logic [NUM_STAGES-1:0]                  stage_stop,
    input  logic [NUM_STAGES-1:0]                  stage_re,
    input  logic [NUM_STAGES*SIZE_address_pix-1:0] stage_addr,
    output logic                                   mem_re,
    output logic [SIZE_address_pix-1:0]            mem_addr,
    output logic [$clog2(NUM_STAGES)-1:0]          cur_stage,
    output logic                                   busy,
    output logic                                   done,
    input  logic [3:0]                             result_in,
    output logic [3:0]                             result_out,
    output logic                                   result_valid,
    output logic                                   error
);
    localparam int SW = $clog2(NUM_STAGES);
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] stage_nx;
    logic          stop_seen;
    logic          last_stage;
    logic          timeout;
    logic          abort;

    assign stop_seen  = stage_stop[cur_stage];
    assign last_stage = (cur_stage == LAST);

`ifdef WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        err_q;

    assign timeout = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign abort   = err_q;
    assign error   = err_q;

    // Counter idles at zero outside RUN, so every stage starts with a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == RUN)
                wd_cnt <= wd_cnt + 16'd1;
            else
                wd_cnt <= '0;
            if (state == IDLE && start)
                err_q <= 1'b0;
            else if (state == RUN && !stop_seen && timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign abort   = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        stage_nx = cur_stage;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    stage_nx = '0;
                end
            end
            RUN: begin
                if (stop_seen || timeout)
                    state_nx = GAP;
            end
            GAP: begin
                if (!last_stage && !abort) begin
                    state_nx = RUN;
                    stage_nx = cur_stage + 1'b1;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The result stage updates RESULT together with STOP, so latch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_stage    <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cur_stage <= stage_nx;
            if (state == RUN && stop_seen && last_stage)
                result_out <= result_in;
            if (state == IDLE && start)
                result_valid <= 1'b0;
            else if (state == GAP && last_stage && !abort)
                result_valid <= 1'b1;
        end
    end

    always_comb begin
        stage_en = '0;
        mem_re   = 1'b0;
        mem_addr = '0;
        if (state == RUN) begin
            stage_en[cur_stage] = 1'b1;
            mem_re   = stage_re[cur_stage];
            mem_addr = stage_addr[cur_stage*SIZE_address_pix +: SIZE_address_pix];
        end
    end

    assign busy = (state == RUN) || (state == GAP);
    assign done = (state == DONE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer: stage models with programmable STOP latency, expected behaviour
// derived from an arithmetic schedule of the run (stage windows, gaps, done cycle).
module tb_layer_sequencer;
    localparam int N  = 4;
    localparam int AW = 13;
    localparam int CW = $clog2(N);
`ifdef WATCHDOG_EN
    localparam int TO = 20;
`else
    localparam int TO = 65535;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [N-1:0]    stage_en;
    logic [N-1:0]    stage_stop;
    logic [N-1:0]    stage_re;
    logic [N*AW-1:0] stage_addr;
    logic            mem_re;
    logic [AW-1:0]   mem_addr;
    logic [CW-1:0]   cur_stage;
    logic            busy, done;
    logic [3:0]      result_in = 4'd0;
    logic [3:0]      result_out;
    logic            result_valid, error;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            lat [N];
    int            cnt [N];
    logic [N-1:0]  spur = '0;
    logic [N-1:0]  re_v = '0;
    logic [AW-1:0] addr_v [N];

    layer_sequencer #(.NUM_STAGES(N), .SIZE_address_pix(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stage_en(stage_en), .stage_stop(stage_stop),
        .stage_re(stage_re), .stage_addr(stage_addr), .mem_re(mem_re), .mem_addr(mem_addr),
        .cur_stage(cur_stage), .busy(busy), .done(done), .result_in(result_in),
        .result_out(result_out), .result_valid(result_valid), .error(error)
    );

    always #5 clk = ~clk;

    // Stage model: counts its enabled cycles and raises STOP after lat[k] of them, low when disabled.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) cnt[k] <= stage_en[k] ? cnt[k] + 1 : 0;
    end

    always_comb begin
        stage_re = re_v;
        stage_addr = '0;
        stage_stop = '0;
        for (int k = 0; k < N; k++) begin
            stage_addr[k*AW +: AW] = addr_v[k];
            stage_stop[k] = (stage_en[k] && cnt[k] >= lat[k]) || spur[k];
        end
    end

    task automatic run_and_check(input string tag, input bit rnd_data, input bit spur_on,
                                 input bit start_noise);
        int a [N+1];
        int len [N];
        int cap, st, k;
        logic [3:0]    exp_res;
        logic [N-1:0]  exp_en, excl;
        logic          exp_re;
        logic [AW-1:0] exp_addr;
        a[0] = 0;
        for (int j = 0; j < N; j++) begin
            len[j] = lat[j] + 1;
            a[j+1] = a[j] + len[j] + 1;
        end
        cap = a[N-1] + len[N-1] - 1;
        exp_res = result_in;
        start = 1'b1;
        for (int c = 0; c <= a[N] + 1; c++) begin
            @(negedge clk);
            st = 0;
            k = N - 1;
            for (int j = 0; j < N; j++) begin
                if (c >= a[j] && c < a[j] + len[j]) begin st = 1; k = j; end
                else if (c == a[j] + len[j]) begin st = 2; k = j; end
            end
            if (c == a[N]) st = 3;
            exp_en = '0;
            if (st == 1) exp_en[k] = 1'b1;
            exp_re   = (st == 1) ? re_v[k] : 1'b0;
            exp_addr = (st == 1) ? addr_v[k] : '0;
            n_cmp += 9;
            if (stage_en !== exp_en) begin n_bad++;
                $display("[TB] FAIL %s stage_en c=%0d got %b want %b", tag, c, stage_en, exp_en); end
            if (busy !== (st == 1 || st == 2)) begin n_bad++;
                $display("[TB] FAIL %s busy c=%0d got %b want %b", tag, c, busy, (st == 1 || st == 2)); end
            if (done !== (st == 3)) begin n_bad++;
                $display("[TB] FAIL %s done c=%0d got %b want %b", tag, c, done, (st == 3)); end
            if (cur_stage !== CW'(k)) begin n_bad++;
                $display("[TB] FAIL %s cur_stage c=%0d got %0d want %0d", tag, c, cur_stage, k); end
            if (mem_re !== exp_re) begin n_bad++;
                $display("[TB] FAIL %s mem_re c=%0d got %b want %b", tag, c, mem_re, exp_re); end
            if (mem_addr !== exp_addr) begin n_bad++;
                $display("[TB] FAIL %s mem_addr c=%0d got %h want %h", tag, c, mem_addr, exp_addr); end
            if (result_valid !== (c >= a[N])) begin n_bad++;
                $display("[TB] FAIL %s result_valid c=%0d got %b want %b", tag, c, result_valid, (c >= a[N])); end
            if (error !== 1'b0) begin n_bad++;
                $display("[TB] FAIL %s error c=%0d got %b want 0", tag, c, error); end
            if (c > cap && result_out !== exp_res) begin n_bad++;
                $display("[TB] FAIL %s result_out c=%0d got %0d want %0d", tag, c, result_out, exp_res); end
            if (rnd_data) begin
                re_v = N'($urandom);
                for (int j = 0; j < N; j++) addr_v[j] = AW'($urandom);
                result_in = 4'($urandom);
            end
            if (c == cap) exp_res = result_in;
            excl = '0;
            if (st == 1) excl[k] = 1'b1;
            spur  = spur_on ? (N'($urandom) & ~excl) : '0;
            start = (start_noise && c <= a[N]) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        spur = '0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp += 9;
        if ({stage_en, mem_re, mem_addr, cur_stage, busy, done, result_out, result_valid, error} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs got en=%b re=%b addr=%h cs=%0d busy=%b done=%b res=%0d rv=%b err=%b want all 0",
                     stage_en, mem_re, mem_addr, cur_stage, busy, done, result_out, result_valid, error);
        end
        n_bad += 8;
        if (stage_en === '0 && mem_re === 1'b0 && mem_addr === '0 && cur_stage === '0) n_bad -= 4;
        if (busy === 1'b0 && done === 1'b0 && result_out === '0 && result_valid === 1'b0) n_bad -= 4;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        for (int j = 0; j < N; j++) begin lat[j] = 9; addr_v[j] = '0; end
        re_v = '0;
        result_in = 4'd7;
        run_and_check("normal", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mem_mux();
        for (int j = 0; j < N; j++) begin lat[j] = 3 + j; addr_v[j] = AW'(j * 'h111); end
        addr_v[1] = 13'h0FFF;
        addr_v[2] = 13'h0123;
        re_v = '1;
        result_in = 4'd9;
        run_and_check("mem_mux", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_spurious_stop();
        for (int j = 0; j < N; j++) lat[j] = $urandom_range(4, 12);
        run_and_check("spurious", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_stop_same_cycle();
        for (int j = 0; j < N; j++) lat[j] = 0;
        run_and_check("stop_first_cycle", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < N; j++) lat[j] = $urandom_range(1, 8);
            run_and_check("start_ignored", 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid_run();
        int tgt;
        for (int j = 0; j < N; j++) lat[j] = $urandom_range(3, 10);
        re_v = '1;
        result_in = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tgt = lat[0] + 2 + $urandom_range(0, lat[1]);
        repeat (tgt) @(negedge clk);
        n_cmp++;
        if (stage_en !== 4'b0010) begin n_bad++;
            $display("[TB] FAIL midrun_stage1 got %b want 0010", stage_en); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 9;
        if (stage_en !== '0) begin n_bad++; $display("[TB] FAIL async_rst stage_en got %b want 0", stage_en); end
        if (mem_re !== 1'b0) begin n_bad++; $display("[TB] FAIL async_rst mem_re got %b want 0", mem_re); end
        if (mem_addr !== '0) begin n_bad++; $display("[TB] FAIL async_rst mem_addr got %h want 0", mem_addr); end
        if (cur_stage !== '0) begin n_bad++; $display("[TB] FAIL async_rst cur_stage got %0d want 0", cur_stage); end
        if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL async_rst busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL async_rst done got %b want 0", done); end
        if (result_out !== '0) begin n_bad++; $display("[TB] FAIL async_rst result_out got %0d want 0", result_out); end
        if (result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL async_rst result_valid got %b want 0", result_valid); end
        if (error !== 1'b0) begin n_bad++; $display("[TB] FAIL async_rst error got %b want 0", error); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) lat[j] = $urandom_range(0, 12);
        run_and_check("after_reset", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < N; j++) lat[j] = $urandom_range(0, 12);
            run_and_check("random", 1'b1, 1'b1, 1'b1);
        end
    endtask

`ifdef WATCHDOG_EN
    task automatic test_watchdog();
        logic [N-1:0] exp_en;
        lat[0] = 2;
        lat[1] = 100000;
        start = 1'b1;
        for (int c = 0; c <= 26; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_en = (c < 3) ? 4'b0001 : (c >= 4 && c <= 23) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (stage_en !== exp_en) begin n_bad++;
                $display("[TB] FAIL wd stage_en c=%0d got %b want %b", c, stage_en, exp_en); end
            n_cmp += 2;
            if (done !== (c == 25)) begin n_bad++;
                $display("[TB] FAIL wd done c=%0d got %b want %b", c, done, (c == 25)); end
            if (error !== (c >= 24)) begin n_bad++;
                $display("[TB] FAIL wd error c=%0d got %b want %b", c, error, (c >= 24)); end
            if (c >= 25) begin
                n_cmp += 2;
                if (result_valid !== 1'b0) begin n_bad++;
                    $display("[TB] FAIL wd result_valid c=%0d got %b want 0", c, result_valid); end
                if (busy !== 1'b0) begin n_bad++;
                    $display("[TB] FAIL wd busy c=%0d got %b want 0", c, busy); end
            end
        end
        lat[1] = 5;
    endtask
`endif

    initial begin
        for (int j = 0; j < N; j++) begin lat[j] = 0; addr_v[j] = '0; end
        test_reset();
        test_normal();
        test_mem_mux();
        test_spurious_stop();
        test_stop_same_cycle();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
